// File: rtl/agu_rdport_pkg.sv
// agu_rdport_pkg
// Shared definitions for the AGU read-issue stage: FSM state encoding,
// the AGU zero-flag tag width and a parameter legality helper.
package agu_rdport_pkg;

    localparam int TAG_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLR   = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // RDLAT must be at least one cycle; DEPTH must be a power of two >= 1.
    function automatic bit cfg_ok(input int rdlat, input int depth);
        return (rdlat >= 1) && (depth >= 1) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/agu_rdport_if.sv
// agu_rdport_if
// Bus bundle between the read-issue stage and its neighbours.
//   agu_clr/agu_step   : AGU control strobes
//   agu_addr/agu_z     : AGU address and {z3,z2,z1,z0} flags
//   mem_rd_en/addr/data: memory read port (data returns RDLAT cycles later)
//   out_valid/ready/data/last/tag : operand stream toward the MVU
// Modports: master = agu_rdport side, slave = surrounding environment.
interface agu_rdport_if
    import agu_rdport_pkg::*;
#(
    parameter int BWADDR = 21,
    parameter int BWDATA = 64
);
    logic              agu_clr;
    logic              agu_step;
    logic [BWADDR-1:0] agu_addr;
    logic [TAG_W-1:0]  agu_z;
    logic              mem_rd_en;
    logic [BWADDR-1:0] mem_rd_addr;
    logic [BWDATA-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [BWDATA-1:0] out_data;
    logic              out_last;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output agu_clr, agu_step, mem_rd_en, mem_rd_addr,
        output out_valid, out_data, out_last, out_tag,
        input  agu_addr, agu_z, mem_rd_data, out_ready
    );

    modport slave (
        input  agu_clr, agu_step, mem_rd_en, mem_rd_addr,
        input  out_valid, out_data, out_last, out_tag,
        output agu_addr, agu_z, mem_rd_data, out_ready
    );
endinterface

// File: rtl/agu_rdport_fifo.sv
// agu_rdport_fifo
// Synchronous FIFO, parameterized width/depth, async active-low clear.
// Ports: clk, rst_n, push/wdata (write), pop (read), rdata (head word,
// combinational), empty, cnt (occupancy). Push while full is accepted only
// when a pop happens in the same cycle.
module agu_rdport_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && full && !pop)) else $error("agu_rdport_fifo overflow");
    end

endmodule

// File: rtl/agu_rdport.sv
// agu_rdport
// Read-issue stage behind the AGU: runs a job of `count` reads, drives AGU
// clr/step, issues one memory read per step, absorbs RDLAT cycles of memory
// latency and returns words through a credit-protected output FIFO.
// Ports: clk, rst_n (async, active-low), start/count (job request),
// busy/done (job status), bus (agu_rdport_if.master: AGU, memory, output).
// Optional feature: define AGU_RDPORT_TAG_EN to carry agu_z captured at issue
// through to out_tag; otherwise out_tag is 0 and agu_z is ignored.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start
// CLR      | one cycle of agu_clr, job length latched
// RUN      | issuing reads while words remain and credit > 0
// DRAIN    | all issued; waiting for in-flight reads and FIFO to empty
module agu_rdport
    import agu_rdport_pkg::*;
#(
    parameter int BWADDR  = 21,
    parameter int BWDATA  = 64,
    parameter int BWCOUNT = 16,
    parameter int RDLAT   = 2,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BWCOUNT-1:0] count,
    output logic               busy,
    output logic               done,
    agu_rdport_if.master       bus
);
    localparam int CW  = $clog2(DEPTH + RDLAT + 1);
    localparam int FCW = $clog2(DEPTH + 1);
`ifdef AGU_RDPORT_TAG_EN
    localparam int FW = BWDATA + 1 + TAG_W;
`else
    localparam int FW = BWDATA + 1;
`endif

    state_t             state;
    logic [BWCOUNT-1:0] remaining;
    logic [RDLAT-1:0]   pipe_v, pipe_last;
    logic [CW-1:0]      inflight;
    logic [FCW-1:0]     fifo_cnt;
    logic               fifo_empty, credit_ok, issue, is_last, push, pop;
    logic [FW-1:0]      fifo_wdata, fifo_rdata;
    logic [BWADDR-1:0]  rd_addr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RDLAT; i++) inflight = inflight + CW'(pipe_v[i]);
    end

    // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
    assign credit_ok = (CW'(fifo_cnt) + inflight) < CW'(DEPTH);
    assign issue     = (state == ST_RUN) && (remaining != '0) && credit_ok;
    assign is_last   = (remaining == BWCOUNT'(1));
    assign rd_addr   = issue ? bus.agu_addr : '0;

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DRAIN) && (inflight == '0) && fifo_empty;
    assign bus.agu_clr   = (state == ST_CLR);
    assign bus.agu_step  = issue;
    assign bus.mem_rd_en = issue;
    assign bus.mem_rd_addr = rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_CLR;
                    remaining <= count;
                end
                ST_CLR:  state <= (remaining == '0) ? ST_DRAIN : ST_RUN;
                ST_RUN:  if (issue) begin
                    remaining <= remaining - BWCOUNT'(1);
                    if (is_last) state <= ST_DRAIN;
                end
                ST_DRAIN: if (done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Return pipeline: stage RDLAT-1 lines up with mem_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v[0]    <= issue;
            pipe_last[0] <= issue && is_last;
            for (int i = 1; i < RDLAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

`ifdef AGU_RDPORT_TAG_EN
    logic [TAG_W-1:0] pipe_tag [RDLAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RDLAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_tag[0] <= bus.agu_z;
            for (int i = 1; i < RDLAT; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    assign fifo_wdata  = {pipe_tag[RDLAT-1], pipe_last[RDLAT-1], bus.mem_rd_data};
    assign bus.out_tag = fifo_rdata[FW-1 -: TAG_W];
`else
    logic unused_agu_z;
    assign unused_agu_z = ^bus.agu_z;
    assign fifo_wdata   = {pipe_last[RDLAT-1], bus.mem_rd_data};
    assign bus.out_tag  = '0;
`endif

    assign push = pipe_v[RDLAT-1];
    assign pop  = !fifo_empty && bus.out_ready;

    agu_rdport_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_rdata[BWDATA-1:0];
    assign bus.out_last  = fifo_rdata[BWDATA];

    always_ff @(posedge clk) begin
        assert (cfg_ok(RDLAT, DEPTH)) else $error("agu_rdport: illegal RDLAT/DEPTH");
    end

endmodule

// File: tb/tb_agu_rdport.sv
// Testbench for agu_rdport: behavioural AGU and fixed-latency memory models,
// table of directed jobs, hand-written mid-job reset, random jobs.
module tb_agu_rdport;
    import agu_rdport_pkg::*;

    localparam int BWADDR  = 21;
    localparam int BWDATA  = 64;
    localparam int BWCOUNT = 16;
    localparam int RDLAT   = 2;
    localparam int DEPTH   = 4;
    localparam int LIMIT   = 400;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [BWCOUNT-1:0] count = '0;
    logic               busy, done;

    agu_rdport_if #(.BWADDR(BWADDR), .BWDATA(BWDATA)) bus ();

    agu_rdport #(
        .BWADDR(BWADDR), .BWDATA(BWDATA), .BWCOUNT(BWCOUNT),
        .RDLAT(RDLAT), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AGU model: two-level walk, inner loop of l0+1 steps of j0, wrap adds j1.
    int cfg_l0 = 0;
    int cfg_j0 = 0;
    int cfg_j1 = 0;
    logic [BWADDR-1:0] agu_a = '0;
    int agu_c0 = 0;

    always @(posedge clk) begin
        if (bus.agu_clr) begin
            agu_a  <= '0;
            agu_c0 <= 0;
        end else if (bus.agu_step) begin
            if (agu_c0 == cfg_l0) begin
                agu_c0 <= 0;
                agu_a  <= agu_a + BWADDR'(cfg_j1);
            end else begin
                agu_c0 <= agu_c0 + 1;
                agu_a  <= agu_a + BWADDR'(cfg_j0);
            end
        end
    end
    assign bus.agu_addr = agu_a;
    assign bus.agu_z    = {3'b000, agu_c0 == cfg_l0};

    // Memory model: returns data = address RDLAT cycles after the strobe.
    logic [BWADDR-1:0] mq_a [RDLAT] = '{default: '0};
    logic              mq_v [RDLAT] = '{default: 1'b0};

    always @(posedge clk) begin
        mq_v[0] <= bus.mem_rd_en;
        mq_a[0] <= bus.mem_rd_addr;
        for (int i = 1; i < RDLAT; i++) begin
            mq_v[i] <= mq_v[i-1];
            mq_a[i] <= mq_a[i-1];
        end
    end
    assign bus.mem_rd_data = mq_v[RDLAT-1] ? 64'(mq_a[RDLAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    // Reference: closed-form address of the i-th read of a job.
    function automatic logic [BWADDR-1:0] ref_addr(input int i, input int l0, input int j0, input int j1);
        int grp = i / (l0 + 1);
        int pos = i % (l0 + 1);
        return BWADDR'(grp * (l0 * j0 + j1) + pos * j0);
    endfunction

    function automatic logic [3:0] ref_tag(input int i, input int l0);
`ifdef AGU_RDPORT_TAG_EN
        return {3'b000, (i % (l0 + 1)) == l0};
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic ready_for(input int rmode, input int cyc);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return 1'($urandom_range(0, 1));
        return (cyc >= 20);
    endfunction

    typedef struct {
        int n;
        int l0;
        int j0;
        int j1;
        int rmode;     // 0: always ready, 1: random ready, 2: stalled until cycle 20
        int restart;   // cycle of a second start pulse, -1 for none
        int exp_done;  // expected done cycle, -1 when ready is random/stalled
    } vec_t;

    task automatic run_job(input vec_t v);
        int cyc = 0, issues = 0, steps = 0, words = 0, dones = 0;
        int busy_cyc = 0, done_cyc = -1, first_iss = -1, first_val = -1;
        cfg_l0 = v.l0;
        cfg_j0 = v.j0;
        cfg_j1 = v.j1;
        @(negedge clk);
        start = 1'b1;
        count = BWCOUNT'(v.n);
        bus.out_ready = ready_for(v.rmode, 0);
        while (cyc < LIMIT && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            if (cyc == v.restart) begin
                start = 1'b1;
                count = BWCOUNT'(9);
            end else begin
                start = 1'b0;
            end
            bus.out_ready = ready_for(v.rmode, cyc);
            if (cyc == 1) begin
                check("agu_clr_cycle1", 64'(bus.agu_clr), 64'd1);
                check("busy_cycle1", 64'(busy), 64'd1);
            end
            if (busy) busy_cyc++;
            if (bus.agu_step) steps++;
            if (bus.mem_rd_en) begin
                if (first_iss < 0) first_iss = cyc;
                check("rd_addr", 64'(bus.mem_rd_addr), 64'(ref_addr(issues, v.l0, v.j0, v.j1)));
                check("step_with_rd", 64'(bus.agu_step), 64'd1);
                issues++;
                check("credit_bound", 64'((issues - words) <= DEPTH), 64'd1);
            end
            if (bus.out_valid) begin
                if (first_val < 0) first_val = cyc;
                if (bus.out_ready) begin
                    check("out_data", bus.out_data, 64'(ref_addr(words, v.l0, v.j0, v.j1)));
                    check("out_last", 64'(bus.out_last), 64'(words == v.n - 1));
                    check("out_tag", 64'(bus.out_tag), 64'(ref_tag(words, v.l0)));
                    words++;
                end
            end
            if (v.rmode == 2 && cyc == 19) check("bp_issues_stalled", 64'(issues), 64'(DEPTH));
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        check("issue_count", 64'(issues), 64'(v.n));
        check("step_count", 64'(steps), 64'(v.n));
        check("word_count", 64'(words), 64'(v.n));
        check("done_pulses", 64'(dones), 64'd1);
        check("busy_cycles", 64'(busy_cyc), 64'(done_cyc));
        if (v.exp_done >= 0) check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        if (v.n > 0) begin
            check("first_issue_cycle", 64'(first_iss), 64'd2);
            check("first_valid_cycle", 64'(first_val), 64'(3 + RDLAT));
        end else begin
            check("zero_len_no_issue", 64'(first_iss), 64'(-1));
        end
    endtask

    task automatic midjob_reset();
        int seen = 0;
        cfg_l0 = 0;
        cfg_j0 = 0;
        cfg_j1 = 1;
        @(negedge clk);
        start = 1'b1;
        count = BWCOUNT'(10);
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid || busy || bus.mem_rd_en || done) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        vecs[0] = '{n: 5, l0: 1, j0: 1, j1: 16,  rmode: 0, restart: -1, exp_done: 10};
        vecs[1] = '{n: 1, l0: 0, j0: 3, j1: 7,   rmode: 0, restart: -1, exp_done: 6};
        vecs[2] = '{n: 0, l0: 1, j0: 1, j1: 1,   rmode: 0, restart: -1, exp_done: 2};
        vecs[3] = '{n: 3, l0: 2, j0: 2, j1: 100, rmode: 0, restart: 2,  exp_done: 8};
        vecs[4] = '{n: 8, l0: 0, j0: 5, j1: 1,   rmode: 2, restart: -1, exp_done: -1};
        vecs[5] = '{n: 7, l0: 3, j0: 2, j1: 9,   rmode: 0, restart: -1, exp_done: 12};

        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ctrl", 64'({bus.agu_clr, bus.agu_step, bus.mem_rd_en}), 64'd0);
        check("reset_out", 64'({bus.out_valid, bus.out_last, bus.out_tag}), 64'd0);
        check("reset_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
        check("reset_out_data", bus.out_data, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) run_job(vecs[v]);

        midjob_reset();
        run_job(vecs[0]);

        for (int r = 0; r < 6; r++) begin
            rv.n        = int'($urandom_range(1, 12));
            rv.l0       = int'($urandom_range(0, 3));
            rv.j0       = int'($urandom_range(0, 255));
            rv.j1       = int'($urandom_range(0, 255));
            rv.rmode    = 1;
            rv.restart  = -1;
            rv.exp_done = -1;
            run_job(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/agu_rdport.md
# agu_rdport

Read-issue stage directly downstream of the address generation unit (AGU). It sequences a job of N reads, drives the AGU's `clr`/`step`, and issues one memory read per step at the AGU's current address. It absorbs the memory's fixed read latency and returns data through a credit-protected output FIFO with a valid/ready handshake. It is the block that turns AGU address streams into operand words for the MVU datapath.

## Interface
- `BWADDR`, 21: address width; matches AGU.
- `BWDATA`, 64: memory data width.
- `BWCOUNT`, 16: job length counter width.
- `RDLAT`, 2: fixed memory read latency in cycles, ≥1.
- `DEPTH`, 4: output FIFO depth, power of 2, ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle job start pulse; ignored unless idle.
- `count` in BWCOUNT: number of reads in the job; sampled with `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse when the job completes.
- `agu_clr` out 1: drives AGU `clr`.
- `agu_step` out 1: drives AGU `step`.
- `agu_addr` in BWADDR: AGU `addr_out`.
- `agu_z` in 4: AGU `{z3_out,z2_out,z1_out,z0_out}`.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out BWADDR: memory read address.
- `mem_rd_data` in BWDATA: valid exactly RDLAT cycles after `mem_rd_en`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head word.
- `out_data` out BWDATA: head data.
- `out_last` out 1: head is the final word of the job.
- `out_tag` out 4: `agu_z` captured at issue (feature-gated, see Configuration).

## Operation
- States: IDLE, CLR, RUN, DRAIN.
  - IDLE→CLR on `start`. At the same time, `remaining` loads `count`.
  - CLR lasts one cycle with `agu_clr`=1, then goes to RUN. If `remaining`==0, it goes to DRAIN instead.
  - RUN→DRAIN on the cycle the last read issues.
  - DRAIN→IDLE when in-flight==0 and the FIFO is empty. `done` pulses in that transition cycle.
- Issue condition in RUN: `remaining`>0 and `credit`>0. In an issue cycle:
  - `agu_step`=`mem_rd_en`=1 and `mem_rd_addr`=`agu_addr` (combinational pass-through).
  - `remaining` decrements.
- `credit` = DEPTH − fifo_count − inflight, computed from registered values only. It has no combinational path from `out_ready`, so a pop frees credit on the next cycle.
- Return path: a shift register of RDLAT stages carries {valid, last, tag}. When its output is valid, `mem_rd_data` is written into the FIFO together with last/tag.
- `last` is set on the issue where `remaining`==1.
- The FIFO pops when `out_valid`&&`out_ready`. Simultaneous push and pop is legal at any occupancy, including full and empty.
- The credit rule guarantees the FIFO never overflows. An internal overflow is a design error (assertion).
- `count`==0: no AGU step and no reads. `done` pulses 2 cycles after `start`.
- `start` while `busy` is ignored and has no side effects.
- Counters use modular arithmetic of width BWCOUNT; `count`=2^BWCOUNT−1 is legal.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `agu_clr`, `agu_step`, `mem_rd_en`, `out_valid`, `out_last` = 0.
  - `out_tag`, `mem_rd_addr`, `out_data` = 0.
  - FIFO, pipeline and counters are empty/0.
- `start` at cycle 0: `busy`=1 from cycle 1, `agu_clr`=1 in cycle 1, first issue in cycle 2 at address 0.
- First `out_valid` appears in cycle 3+RDLAT.
- Sustained 1 read/cycle requires DEPTH ≥ RDLAT+2. Smaller DEPTH is correct but throttled.
- Reset asserted mid-job: all state clears immediately. In-flight memory returns after deassertion are discarded because the pipeline valid bits were cleared.

## Configuration
- `AGU_RDPORT_TAG_EN`
  - Defined: tag bits are stored in the pipeline and FIFO, and `out_tag` carries `agu_z` as captured at the issue cycle.
  - Undefined: there is no tag storage and `out_tag` is tied to 0. `agu_z` is unused.

## Structure
- Shared package: state enum (IDLE/CLR/RUN/DRAIN), tag width constant (4), RDLAT/DEPTH legality checks.
- One sub-module: `agu_rdport_fifo`, a synchronous FIFO with parameterized width/depth, `rst_n` async clear, and count output.

## Test plan
- Streaming: count=5, RDLAT=2, `out_ready`=1, memory returns data=addr, AGU l0=1/j0=1/j1=16 → `out_data` 0,1,17,18,34; `out_last` on the 5th word; `done` pulses once.
- Backpressure: count=8, DEPTH=4, `out_ready`=0 → exactly 4 `mem_rd_en` pulses, then stall. Raise `out_ready` → the remaining 4 issue, order is preserved, no loss.
- Zero length: `start` with count=0 → no `agu_step` or `mem_rd_en`; `done` at cycle 2; `busy` high for cycles 1–2 only.
- Mid-job reset: deassert `rst_n` with 2 reads in flight → `out_valid`=0 immediately, state IDLE; the late returns never appear at the output.
- Ignored start: second `start` during RUN with count=3 → the job still completes with the original count.
- Tag (`AGU_RDPORT_TAG_EN`): l0=1, l1=0 → `out_tag` sequence 0000, 0001, 0000, 0001 (bit0 per z0 at issue).
